// File: rtl/xilinx_sdp_bram_fifo_ctrl.sv
// FIFO controller for a simple-dual-port block RAM plus a small output buffer.
// Optional almost-full flag: define XILINX_SDP_FIFO_AFULL_EN.
module xilinx_sdp_bram_fifo_ctrl #(
  parameter int DATA_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 9,
  parameter int DO_REG       = 0,
  parameter int AFULL_THRESH = 500
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic [ADDR_WIDTH+1:0] COUNT,
  output logic                  AFULL,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  output logic [14:0]           BRAM_WRADDR,
  output logic [7:0]            BRAM_WE,
  output logic                  BRAM_WREN,
  output logic [14:0]           BRAM_RDADDR,
  output logic                  BRAM_RDEN,
  output logic                  BRAM_REGCE,
  output logic                  BRAM_RST,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int LAT = 1 + DO_REG;
  localparam int OB_DEPTH = 2 + DO_REG;
  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [2:0] OB_D = 3'(OB_DEPTH);
  localparam logic [1:0] OB_LAST = 2'(OB_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count;
  logic [ADDR_WIDTH:0]   mem_count_n;
  logic [LAT-1:0]        rd_pipe;
  logic [LAT-1:0]        rd_pipe_n;
  logic [1:0]            inflight;
  logic [1:0]            inflight_n;
  logic [1:0]            ob_count;
  logic [1:0]            ob_count_n;
  logic [1:0]            ob_head;
  logic [1:0]            ob_tail;
  logic [DATA_WIDTH-1:0] ob_mem [4];
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_n;
  logic [2:0]            occ;
  logic                  wr_fire;
  logic                  rd_issue;
  logic                  rd_pop;
  logic                  ob_push;

  // Memory is full exactly when the top bit of mem_count is set.
  assign WR_READY = !RST && !mem_count[ADDR_WIDTH];
  assign wr_fire  = WR_VALID && WR_READY;
  assign RD_VALID = !RST && (ob_count != 2'd0);
  assign rd_pop   = RD_VALID && RD_READY;
  assign RD_DATA  = ob_mem[ob_head];
  assign ob_push  = rd_pipe[LAT-1];
  assign occ      = {1'b0, inflight} + {1'b0, ob_count};

  // A pop this cycle frees a slot, which keeps one read per cycle.
  assign rd_issue = !RST && (mem_count != '0) &&
                    ((occ < OB_D) || rd_pop);

  always_comb begin
    inflight = 2'd0;
    for (int i = 0; i < LAT; i++)
      inflight = inflight + {1'b0, rd_pipe[i]};
  end

  always_comb begin
    rd_pipe_n = '0;
    rd_pipe_n[0] = rd_issue;
    for (int i = 1; i < LAT; i++)
      rd_pipe_n[i] = rd_pipe[i-1];
    inflight_n = 2'd0;
    for (int i = 0; i < LAT; i++)
      inflight_n = inflight_n + {1'b0, rd_pipe_n[i]};
  end

  always_comb begin
    mem_count_n = mem_count;
    unique case ({wr_fire, rd_issue})
      2'b10:   mem_count_n = mem_count + 1'b1;
      2'b01:   mem_count_n = mem_count - 1'b1;
      default: mem_count_n = mem_count;
    endcase
    ob_count_n = ob_count + {1'b0, ob_push} - {1'b0, rd_pop};
    count_n = {1'b0, mem_count_n} + CW'(inflight_n) +
              CW'(ob_count_n);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      rd_pipe   <= '0;
      ob_count  <= '0;
      ob_head   <= '0;
      ob_tail   <= '0;
      count_q   <= '0;
    end else begin
      if (wr_fire)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue)
        rd_ptr <= rd_ptr + 1'b1;
      mem_count <= mem_count_n;
      rd_pipe   <= rd_pipe_n;
      ob_count  <= ob_count_n;
      count_q   <= count_n;
      if (ob_push)
        ob_tail <= (ob_tail == OB_LAST) ? 2'd0 : ob_tail + 2'd1;
      if (rd_pop)
        ob_head <= (ob_head == OB_LAST) ? 2'd0 : ob_head + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (ob_push)
      ob_mem[ob_tail] <= BRAM_DO;
  end

  assign COUNT = count_q;

`ifdef XILINX_SDP_FIFO_AFULL_EN
  logic afull_q;

  always_ff @(posedge CLK) begin
    if (RST)
      afull_q <= 1'b0;
    else
      afull_q <= (count_q >= CW'(AFULL_THRESH));
  end

  assign AFULL = afull_q;
`else
  assign AFULL = 1'b0;
`endif

  assign BRAM_DI     = WR_DATA;
  assign BRAM_WRADDR = 15'(wr_ptr);
  assign BRAM_WE     = {8{wr_fire}};
  assign BRAM_WREN   = wr_fire;
  assign BRAM_RDADDR = 15'(rd_ptr);
  assign BRAM_RDEN   = rd_issue;
  assign BRAM_REGCE  = (DO_REG != 0) ? 1'b1 : 1'b0;
  assign BRAM_RST    = RST;

endmodule

// File: doc/xilinx_sdp_bram_fifo_ctrl.md
XILINX_SDP_BRAM_FIFO_CTRL -- requirements
Module: xilinx_sdp_bram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 36, FIFO word width, 1-72.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, BRAM address bits; memory depth is 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DO_REG, default 0, matching the attached BRAM output register setting (0 or 1).
REQ-004 SHALL have parameter AFULL_THRESH, default 500, almost-full level in total entries.
REQ-005 SHALL have port CLK  in  1  single clock for all logic and both BRAM ports.
REQ-006 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports WR_DATA  in  DATA_WIDTH, WR_VALID  in  1, WR_READY  out  1: write stream.
REQ-008 SHALL have ports RD_DATA  out  DATA_WIDTH, RD_VALID  out  1, RD_READY  in  1: read stream.
REQ-009 SHALL have ports COUNT  out  ADDR_WIDTH+2, total entries held; AFULL  out  1, almost-full flag.
REQ-010 SHALL have BRAM-side ports BRAM_DI out DATA_WIDTH, BRAM_WRADDR out 15, BRAM_WE out 8, BRAM_WREN out 1, BRAM_RDADDR out 15, BRAM_RDEN out 1, BRAM_REGCE out 1, BRAM_RST out 1, BRAM_DO in DATA_WIDTH.

Function
REQ-011 SHALL accept a write on a CLK edge where WR_VALID and WR_READY are both high, driving BRAM_WREN=1, BRAM_WE=8'hFF, BRAM_WRADDR=wr_ptr (zero-extended), and BRAM_DI=WR_DATA in that same cycle.
REQ-012 SHALL drive WR_READY=1 when mem_count < 2**ADDR_WIDTH and RST is low; otherwise 0.
REQ-013 SHALL increment wr_ptr modulo 2**ADDR_WIDTH on each accepted write and wrap from all-ones to 0.
REQ-014 SHALL issue a BRAM read (BRAM_RDEN=1, BRAM_RDADDR=rd_ptr) in any cycle where mem_count>0 and (inflight+ob_count) < 2+DO_REG; rd_ptr increments modulo 2**ADDR_WIDTH.
REQ-015 SHALL capture BRAM_DO into the output buffer exactly 1+DO_REG cycles after the issuing BRAM_RDEN cycle.
REQ-016 SHALL hold BRAM_REGCE=1 continuously when DO_REG=1 and 0 when DO_REG=0.
REQ-017 SHALL implement the output buffer as an in-order FIFO of 2+DO_REG entries, so no returned word is ever dropped.
REQ-018 SHALL present the output-buffer head on RD_DATA with RD_VALID=1 whenever ob_count>0; a pop occurs when RD_VALID and RD_READY are both high.
REQ-019 SHALL hold RD_DATA stable while RD_VALID=1 and RD_READY=0.
REQ-020 SHALL update mem_count by +1 per accepted write, -1 per issued read, and net 0 when both occur in the same cycle.
REQ-021 SHALL compute COUNT = mem_count + inflight + ob_count, registered, with no wrap.
REQ-022 SHALL deliver first-word latency from write acceptance to RD_VALID of 3+DO_REG cycles when empty.
REQ-023 SHALL never read and write the same address in one cycle, so the BRAM WRITE_MODE setting does not affect behaviour.
REQ-024 SHALL sustain one write and one read per cycle at steady state with RD_READY held high.

Reset
REQ-025 SHALL, with RST high at a CLK edge, clear wr_ptr, rd_ptr, mem_count, inflight, ob_count, COUNT and AFULL to 0.
REQ-026 SHALL force RD_VALID=0, WR_READY=0, BRAM_WREN=0 and BRAM_RDEN=0 while RST is high.
REQ-027 SHALL drive BRAM_RST=RST, and SHALL discard reads in flight when reset occurs mid-operation.
REQ-028 SHALL restore WR_READY=1 on the first cycle after RST deasserts.

Configuration
REQ-029 SHALL compile in the almost-full logic only when XILINX_SDP_FIFO_AFULL_EN is defined. With the macro, AFULL is registered and equals 1 when COUNT >= AFULL_THRESH. Without the macro, AFULL is tied to 0 and no comparator is built.

Verification
REQ-030 SHALL cover this scenario: reset, then write 0x1,0x2,0x3 back-to-back with RD_READY=1 and DO_REG=0 -> RD_VALID rises 3 cycles after the first write; reads return 1,2,3 in order; COUNT returns to 0.
REQ-031 SHALL cover this scenario: with ADDR_WIDTH=4 and RD_READY=0, write 20 words -> WR_READY falls after 16+2 accepted words; COUNT=18; no BRAM_RDEN after the output buffer fills.
REQ-032 SHALL cover this scenario: with ADDR_WIDTH=4, stream 40 words and random RD_READY -> data is in order across pointer wrap, with no loss or duplication.
REQ-033 SHALL cover this scenario: with DO_REG=1, a single write of 0xAB -> RD_VALID after 4 cycles and BRAM_REGCE constantly 1.
REQ-034 SHALL cover this scenario: assert RST for one cycle with 5 entries and 2 reads in flight -> next cycle COUNT=0, RD_VALID=0, WR_READY=1, and no stale word is ever emitted.
REQ-035 SHALL cover this scenario: with XILINX_SDP_FIFO_AFULL_EN defined, AFULL_THRESH=10, and 10 writes -> AFULL=1 the cycle after COUNT reaches 10; without the macro, AFULL stays 0.
